// File: rtl/mem_bus_arbiter_if.sv
// Start/done bus bundle used for both requester ports and the downstream bus.
// A requester holds start/addr/data/we stable until a one-cycle done pulse.
interface mem_bus_arbiter_if;
    logic        start;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] q;
    logic        done;

    // Side that issues requests and receives completions
    modport master (
        output start,
        output we,
        output addr,
        output data,
        input  q,
        input  done
    );

    // Side that serves requests and returns completions
    modport slave (
        input  start,
        input  we,
        input  addr,
        input  data,
        output q,
        output done
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one start/done memory bus between the
// instruction-fetch port and the data-memory port. The winning request is
// latched onto the bus, completion is routed only to the owner, and a
// watchdog aborts grants the bus never completes.
module mem_bus_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.slave  i_port,
    mem_bus_arbiter_if.slave  d_port,
    mem_bus_arbiter_if.master bus,
    output logic              err_timeout
);
    localparam int              WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              WD_EN   = (TIMEOUT > 0);
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : {WD_W{1'b0}};

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    logic [1:0]      state;
    logic            last_owner;
    logic [31:0]     lat_addr;
    logic [31:0]     lat_data;
    logic            lat_we;
    logic [WD_W-1:0] wd;
    logic [31:0]     i_hold;
    logic [31:0]     d_hold;

    logic            any_req;
    logic            pick_i;
    logic            granted;
    logic            expire;
    logic            finish;
    logic [31:0]     deliver;

    assign bus.addr = lat_addr;
    assign bus.data = lat_data;
    assign bus.we   = lat_we;

    // Pick the next owner from IDLE: a lone requester wins, a tie goes to the port that did not own the bus last
    always_comb begin
        any_req = i_port.start || d_port.start;
        if (i_port.start && d_port.start) begin
            pick_i = (last_owner == OWNER_D);
        end else if (i_port.start) begin
            pick_i = 1'b1;
        end else begin
            pick_i = 1'b0;
        end
    end

    // Decode the end of a grant: a genuine bus_done, or a watchdog abort when bus_done is still absent
    always_comb begin
        granted = (state == GRANT_I) || (state == GRANT_D);
        if (WD_EN && granted && !bus.done && (wd == WD_LAST)) begin
            expire = 1'b1;
        end else begin
            expire = 1'b0;
        end
        finish = granted && (bus.done || expire);
        if (bus.done) begin
            deliver = bus.q;
        end else begin
            deliver = 32'h0000_0000;
        end
    end

    // Drive the downstream request and route completion back only to the owner
    always_comb begin
        bus.start   = granted && !finish;
        i_port.done = finish && (state == GRANT_I);
        d_port.done = finish && (state == GRANT_D);
        if (finish && (state == GRANT_I)) begin
            i_port.q = deliver;
        end else begin
            i_port.q = i_hold;
        end
        if (finish && (state == GRANT_D)) begin
            d_port.q = deliver;
        end else begin
            d_port.q = d_hold;
        end
    end

    // Grant state, request latch, round-robin history, watchdog and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_owner  <= OWNER_D;
            lat_addr    <= 32'h0000_0000;
            lat_data    <= 32'h0000_0000;
            lat_we      <= 1'b0;
            wd          <= {WD_W{1'b0}};
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        wd <= {WD_W{1'b0}};
                        if (pick_i) begin
                            state      <= GRANT_I;
                            last_owner <= OWNER_I;
                            lat_addr   <= i_port.addr;
                            lat_data   <= i_port.data;
                            lat_we     <= i_port.we;
                        end else begin
                            state      <= GRANT_D;
                            last_owner <= OWNER_D;
                            lat_addr   <= d_port.addr;
                            lat_data   <= d_port.data;
                            lat_we     <= d_port.we;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (finish) begin
                        state <= IDLE;
                        if (expire) begin
                            err_timeout <= 1'b1;
                        end
                    end else begin
                        wd <= wd + WD_W'(1'b1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Remember the last value delivered to each port so q holds between completions
    always_ff @(posedge clk) begin
        if (reset) begin
            i_hold <= 32'h0000_0000;
            d_hold <= 32'h0000_0000;
        end else begin
            if (finish && (state == GRANT_I)) begin
                i_hold <= deliver;
            end
            if (finish && (state == GRANT_D)) begin
                d_hold <= deliver;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// transaction-level model (owner, age of the grant, last delivered values).
module tb_mem_bus_arbiter;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic err_timeout;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mem_bus_arbiter_if ifc_i ();
    mem_bus_arbiter_if ifc_d ();
    mem_bus_arbiter_if ifc_b ();

    mem_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_port      (ifc_i),
        .d_port      (ifc_d),
        .bus         (ifc_b),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Model: who owns the bus (0 none, 1 I, 2 D), how many cycles into the grant, what was latched
    int          m_owner;
    int          m_age;
    logic        m_last_d;
    logic [31:0] m_addr, m_data, m_iq, m_dq;
    logic        m_we, m_err;

    logic        e_abort, e_fin, e_bus_start, e_i_done, e_d_done;
    logic [31:0] e_deliver, e_i_q, e_d_q;

    function automatic int pick(input logic i_s, input logic d_s, input logic last_d);
        if (i_s && d_s) return last_d ? 1 : 2;
        else if (i_s) return 1;
        else return 2;
    endfunction

    // Expected outputs this cycle from the model and the current bus response
    always_comb begin
        e_abort   = 1'b0;
        e_fin     = 1'b0;
        e_deliver = ifc_b.done ? ifc_b.q : 32'h0;
        if (m_owner != 0) begin
            e_abort = !ifc_b.done && (m_age == TO - 1);
            e_fin   = ifc_b.done || e_abort;
        end
        e_bus_start = (m_owner != 0) && !e_fin;
        e_i_done    = e_fin && (m_owner == 1);
        e_d_done    = e_fin && (m_owner == 2);
        e_i_q       = e_i_done ? e_deliver : m_iq;
        e_d_q       = e_d_done ? e_deliver : m_dq;
    end

    // Advance the model one cycle
    always @(posedge clk) begin
        if (reset) begin
            m_owner <= 0; m_age <= 0; m_last_d <= 1'b1;
            m_addr <= 32'h0; m_data <= 32'h0; m_we <= 1'b0;
            m_iq <= 32'h0; m_dq <= 32'h0; m_err <= 1'b0;
        end else if (m_owner == 0) begin
            if (ifc_i.start || ifc_d.start) begin
                m_owner  <= pick(ifc_i.start, ifc_d.start, m_last_d);
                m_last_d <= (pick(ifc_i.start, ifc_d.start, m_last_d) == 2);
                m_age    <= 0;
                if (pick(ifc_i.start, ifc_d.start, m_last_d) == 1) begin
                    m_addr <= ifc_i.addr; m_data <= ifc_i.data; m_we <= ifc_i.we;
                end else begin
                    m_addr <= ifc_d.addr; m_data <= ifc_d.data; m_we <= ifc_d.we;
                end
            end
        end else if (e_fin) begin
            if (m_owner == 1) m_iq <= e_deliver;
            else m_dq <= e_deliver;
            if (e_abort) m_err <= 1'b1;
            m_owner <= 0;
        end else begin
            m_age <= m_age + 1;
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model each cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check1 ("cmp_bus_start", ifc_b.start, e_bus_start);
            check32("cmp_bus_addr",  ifc_b.addr,  m_addr);
            check32("cmp_bus_data",  ifc_b.data,  m_data);
            check1 ("cmp_bus_we",    ifc_b.we,    m_we);
            check1 ("cmp_i_done",    ifc_i.done,  e_i_done);
            check1 ("cmp_d_done",    ifc_d.done,  e_d_done);
            check32("cmp_i_q",       ifc_i.q,     e_i_q);
            check32("cmp_d_q",       ifc_d.q,     e_d_q);
            check1 ("cmp_err",       err_timeout, m_err);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic i_fin, d_fin;

    initial begin
        ifc_i.start = 1'b0; ifc_i.we = 1'b0; ifc_i.addr = 32'h0; ifc_i.data = 32'h0;
        ifc_d.start = 1'b0; ifc_d.we = 1'b0; ifc_d.addr = 32'h0; ifc_d.data = 32'h0;
        ifc_b.done = 1'b0; ifc_b.q = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1 ("rst_bus_start", ifc_b.start, 1'b0);
        check32("rst_bus_addr",  ifc_b.addr,  32'h0);
        check32("rst_i_q",       ifc_i.q,     32'h0);
        check32("rst_d_q",       ifc_d.q,     32'h0);
        check1 ("rst_err",       err_timeout, 1'b0);
        cyc();
        reset = 1'b0;
        chk_en = 1'b1;

        // Tie after reset: I, D, I with both held, done on the second grant cycle
        ifc_i.start = 1'b1; ifc_i.addr = 32'h1000_0000; ifc_i.data = 32'h0;
        ifc_d.start = 1'b1; ifc_d.addr = 32'h2000_0000; ifc_d.data = 32'h0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            @(negedge clk);
            check32("tie_addr",  ifc_b.addr,  (k == 1) ? 32'h2000_0000 : 32'h1000_0000);
            check1 ("tie_start", ifc_b.start, 1'b1);
            cyc();
            ifc_b.done = 1'b1; ifc_b.q = 32'h1111_0000 + 32'(k);
            @(negedge clk);
            check1("tie_i_done", ifc_i.done, (k != 1));
            check1("tie_d_done", ifc_d.done, (k == 1));
            cyc();
            ifc_b.done = 1'b0;
            if (k == 2) begin
                ifc_i.start = 1'b0; ifc_d.start = 1'b0;
            end
            @(negedge clk);
            check1("tie_gap", ifc_b.start, 1'b0);
        end

        // Single read, bus_done two cycles into the grant
        ifc_i.start = 1'b1; ifc_i.addr = 32'h0000_0100; ifc_i.we = 1'b0;
        cyc();
        @(negedge clk);
        check1 ("rd_start", ifc_b.start, 1'b1);
        check32("rd_addr",  ifc_b.addr,  32'h0000_0100);
        cyc();
        cyc();
        ifc_b.done = 1'b1; ifc_b.q = 32'hCAFE_F00D;
        @(negedge clk);
        check1 ("rd_i_done", ifc_i.done, 1'b1);
        check32("rd_i_q",    ifc_i.q,    32'hCAFE_F00D);
        check1 ("rd_d_done", ifc_d.done, 1'b0);
        cyc();
        ifc_i.start = 1'b0; ifc_b.done = 1'b0;

        // Data write
        ifc_d.start = 1'b1; ifc_d.we = 1'b1; ifc_d.addr = 32'h0000_2000; ifc_d.data = 32'h1234_5678;
        for (int j = 1; j <= 3; j++) begin
            cyc();
            if (j == 3) begin
                ifc_b.done = 1'b1; ifc_b.q = 32'h55AA_55AA;
            end
            @(negedge clk);
            check1 ("wr_we",   ifc_b.we,   1'b1);
            check32("wr_data", ifc_b.data, 32'h1234_5678);
            check1 ("wr_d_done", ifc_d.done, (j == 3));
            check32("wr_i_q",  ifc_i.q,    32'hCAFE_F00D);
        end
        cyc();
        ifc_d.start = 1'b0; ifc_d.we = 1'b0; ifc_b.done = 1'b0;

        // Spurious bus_done while idle
        ifc_b.done = 1'b1; ifc_b.q = 32'hDEAD_BEEF;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check1("sp_i_done", ifc_i.done, 1'b0);
            check1("sp_d_done", ifc_d.done, 1'b0);
            cyc();
        end
        ifc_b.done = 1'b0;

        // Watchdog abort of a data request, then a normal instruction grant
        ifc_d.start = 1'b1; ifc_d.addr = 32'h0000_3000;
        for (int j = 1; j <= TO; j++) begin
            cyc();
            @(negedge clk);
            check1("to_d_done", ifc_d.done, (j == TO));
            check1("to_err_lo", err_timeout, 1'b0);
            if (j == TO) begin
                check32("to_d_q",  ifc_d.q,     32'h0);
                check1 ("to_start", ifc_b.start, 1'b0);
            end
        end
        cyc();
        ifc_d.start = 1'b0;
        ifc_i.start = 1'b1; ifc_i.addr = 32'h0000_0300;
        @(negedge clk);
        check1("to_err_hi", err_timeout, 1'b1);
        check1("to_d_once", ifc_d.done, 1'b0);
        cyc();
        ifc_b.done = 1'b1; ifc_b.q = 32'hA5A5_0001;
        @(negedge clk);
        check32("after_to_addr", ifc_b.addr, 32'h0000_0300);
        check1 ("after_to_done", ifc_i.done, 1'b1);
        check32("after_to_q",    ifc_i.q,    32'hA5A5_0001);
        check1 ("to_err_stick",  err_timeout, 1'b1);
        cyc();
        ifc_i.start = 1'b0; ifc_b.done = 1'b0;

        // Reset on the second cycle of a grant, then a tie goes to I
        ifc_i.start = 1'b1; ifc_i.addr = 32'h0000_0400;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        ifc_i.start = 1'b1; ifc_i.addr = 32'h0000_0500;
        ifc_d.start = 1'b1; ifc_d.addr = 32'h0000_0600;
        @(negedge clk);
        check1("mr_start",  ifc_b.start, 1'b0);
        check1("mr_i_done", ifc_i.done,  1'b0);
        check1("mr_d_done", ifc_d.done,  1'b0);
        check1("mr_err",    err_timeout, 1'b0);
        cyc();
        ifc_b.done = 1'b1; ifc_b.q = 32'h0BAD_F00D;
        @(negedge clk);
        check32("mr_tie_addr", ifc_b.addr, 32'h0000_0500);
        check1 ("mr_tie_done", ifc_i.done, 1'b1);
        cyc();
        ifc_i.start = 1'b0; ifc_d.start = 1'b0; ifc_b.done = 1'b0;
        cyc();

        // Randomized traffic against the model
        i_fin = 1'b0; d_fin = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 499) == 0);
            if (i_fin) ifc_i.start = 1'b0;
            else if (!ifc_i.start && $urandom_range(0, 3) == 0) begin
                ifc_i.start = 1'b1; ifc_i.addr = $urandom; ifc_i.data = $urandom;
                ifc_i.we = 1'($urandom_range(0, 1));
            end else if (ifc_i.start && $urandom_range(0, 63) == 0) ifc_i.start = 1'b0;
            if (d_fin) ifc_d.start = 1'b0;
            else if (!ifc_d.start && $urandom_range(0, 3) == 0) begin
                ifc_d.start = 1'b1; ifc_d.addr = $urandom; ifc_d.data = $urandom;
                ifc_d.we = 1'($urandom_range(0, 1));
            end else if (ifc_d.start && $urandom_range(0, 63) == 0) ifc_d.start = 1'b0;
            ifc_b.done = ($urandom_range(0, 99) < (((n / 200) % 2 == 0) ? 35 : 4));
            ifc_b.q = $urandom;
            @(negedge clk);
            i_fin = e_i_done; d_fin = e_d_done;
            cyc();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
